layer_mv_sequencer: RTL

Row-serial controller for one fully-connected layer, computing y = A·x in Q8.24 fixed point. It fetches weights from an external single-port weight RAM and time-multiplexes a single registered multiply-accumulate across all ROWS×COLS products. Results stream out one row at a time over a valid/ready handshake. It is the low-area alternative to the fully parallel matrix-vector datapath and sits between the layer weight store and the activation stage.

---
 rtl/layer_mv_sequencer_pkg.sv | 23 ++
 rtl/layer_mv_sequencer_if.sv | 33 +++
 rtl/layer_mv_sequencer_fx_mac.sv | 18 +
 rtl/layer_mv_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/layer_mv_sequencer_pkg.sv
// Shared Q8.24 fixed-point constants, FSM encoding and the product truncation helper
// used by the serial matrix-vector layers.
package layer_mv_sequencer_pkg;

  localparam int W          = 32;
  localparam int FRAC       = 24;
  localparam int TRUNC_SIGN = 2*W - 1;       // 63
  localparam int TRUNC_HI   = FRAC + W - 2;  // 54
  localparam int TRUNC_LO   = FRAC;          // 24

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT
  } state_e;

  // Keep the product sign, drop the top integer bits and the low fraction bits.
  function automatic logic [W-1:0] trunc_prod(input logic signed [2*W-1:0] p);
    return {p[TRUNC_SIGN], p[TRUNC_HI:TRUNC_LO]};
  endfunction

endpackage

// File: rtl/layer_mv_sequencer_if.sv
// Start/x capture, weight RAM read port and row-result stream of the serial layer.
interface layer_mv_sequencer_if
  import layer_mv_sequencer_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int COLS = 10
);
  localparam int AW = $clog2(ROWS*COLS);
  localparam int IW = $clog2(ROWS);

  logic              start;
  logic [COLS*W-1:0] x_in;
  logic              busy;
  logic              done;
  logic              wt_rd;
  logic [AW-1:0]     wt_addr;
  logic [W-1:0]      wt_data;
  logic [W-1:0]      y_data;
  logic [IW-1:0]     y_idx;
  logic              y_valid;
  logic              y_ready;

  modport slave (
    input  start, x_in, wt_data, y_ready,
    output busy, done, wt_rd, wt_addr, y_data, y_idx, y_valid
  );

  modport master (
    output start, x_in, wt_data, y_ready,
    input  busy, done, wt_rd, wt_addr, y_data, y_idx, y_valid
  );

endinterface

// File: rtl/layer_mv_sequencer_fx_mac.sv
// Combinational Q8.24 multiply-accumulate: acc_out = acc_in + trunc(a * b), wrapping.
module fx_mac
  import layer_mv_sequencer_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc_in,
  output logic [W-1:0] acc_out
);

  logic signed [2*W-1:0] prod;

  always_comb begin
    prod    = (2*W)'($signed(a)) * (2*W)'($signed(b));
    acc_out = acc_in + trunc_prod(prod);
  end

endmodule

// File: rtl/layer_mv_sequencer.sv
// Row-serial y = A*x controller: one MAC shared over all products, weights from a
// single-port RAM with one-cycle read latency, rows streamed out on valid/ready.
module layer_mv_sequencer
  import layer_mv_sequencer_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int COLS = 10
)(
  input  logic                clk,
  input  logic                reset,
  layer_mv_sequencer_if.slave bus
);

  localparam int AW = $clog2(ROWS*COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS-1);

  state_e                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [CW-1:0]           pcol_q, pcol_d;
  logic                    pend_q, pend_d;
  logic [W-1:0]            acc_q, acc_d;
  logic [0:COLS-1][W-1:0]  x_q, x_d;
  logic                    done_q, done_d;
  logic [W-1:0]            mac_out;

  // pend/pcol track the read issued last cycle, whose data is on wt_data now.
  fx_mac u_mac (
    .a       (bus.wt_data),
    .b       (x_q[pcol_q]),
    .acc_in  (acc_q),
    .acc_out (mac_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pcol_q  <= '0;
      pend_q  <= 1'b0;
      acc_q   <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pcol_q  <= pcol_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_FETCH;
      S_FETCH: if (col_q == LAST_COL) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   if (bus.y_ready) state_d = (row_q == LAST_ROW) ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    x_d    = x_q;
    done_d = 1'b0;
    pend_d = (state_q == S_FETCH);
    pcol_d = col_q;
    acc_d  = pend_q ? mac_out : acc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d   = bus.x_in;
          row_d = '0;
          col_d = '0;
        end
      end
      S_FETCH: begin
        col_d = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
        // First fetch of a row: no read is in flight, so this is the clear slot.
        if (col_q == '0) acc_d = '0;
      end
      S_OUT: begin
        if (bus.y_ready) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            row_d  = '0;
            done_d = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != S_IDLE);
    bus.done    = done_q;
    bus.wt_rd   = 1'b0;
    bus.wt_addr = '0;
    bus.y_valid = 1'b0;
    bus.y_data  = '0;
    bus.y_idx   = '0;
    case (state_q)
      S_FETCH: begin
        bus.wt_rd   = 1'b1;
        bus.wt_addr = AW'(row_q) * AW'(COLS) + AW'(col_q);
      end
      S_OUT: begin
        bus.y_valid = 1'b1;
        bus.y_data  = acc_q;
        bus.y_idx   = row_q;
      end
      default: ;
    endcase
  end

endmodule
